// File: rtl/bexkat1_busarb.sv
// bexkat1_busarb: merges the bexkat1p instruction-fetch and data buses onto
// one shared slave bus. Data wins by default; an instruction request that has
// been refused MAX_WAIT times is forced through. Every grant covers exactly one
// transaction and ends on slave ack, master abort, or a TIMEOUT abort.
module bexkat1_busarb #(
    parameter int MAX_WAIT = 8,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // instruction-fetch master
    input  logic        ins_cyc_i,
    input  logic        ins_we_i,
    input  logic [31:0] ins_adr_i,
    input  logic [3:0]  ins_sel_i,
    input  logic [31:0] ins_dat_i,
    output logic        ins_ack_o,
    output logic        ins_err_o,
    output logic [31:0] ins_dat_o,
    // data master
    input  logic        dat_cyc_i,
    input  logic        dat_we_i,
    input  logic [31:0] dat_adr_i,
    input  logic [3:0]  dat_sel_i,
    input  logic [31:0] dat_dat_i,
    output logic        dat_ack_o,
    output logic        dat_err_o,
    output logic [31:0] dat_dat_o,
    // shared slave bus
    output logic        bus_cyc_o,
    output logic        bus_we_o,
    output logic [31:0] bus_adr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack_i,
    // debug view of the arbiter state
    output logic [1:0]  grant_o
);

    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INS  = 2'b01,
        ST_DAT  = 2'b10
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;

    logic            gnt_ins, gnt_dat, gnt_any;
    logic            gnt_cyc;
    logic            ack_hit;
    logic            tmo_hit;
    logic            starved;

    // Grant decode; gnt_cyc is the granted master's own request line
    always_comb begin
        gnt_ins = (state_q == ST_INS);
        gnt_dat = (state_q == ST_DAT);
        gnt_any = gnt_ins | gnt_dat;
        gnt_cyc = (gnt_ins & ins_cyc_i) | (gnt_dat & dat_cyc_i);
        ack_hit = gnt_any & bus_ack_i;
        // ack in the last allowed cycle beats the timeout
        tmo_hit = gnt_cyc & ~bus_ack_i & (tmo_q == TMO_LAST);
        starved = (starve_q == STARVE_MAX);
    end

    // Route the granted master onto the slave bus; idle bus is all zeros
    always_comb begin
        bus_cyc_o = 1'b0;
        bus_we_o  = 1'b0;
        bus_adr_o = '0;
        bus_sel_o = '0;
        bus_dat_o = '0;
        case (state_q)
            ST_INS: begin
                bus_cyc_o = ins_cyc_i;
                bus_we_o  = ins_we_i;
                bus_adr_o = ins_adr_i;
                bus_sel_o = ins_sel_i;
                bus_dat_o = ins_dat_i;
            end
            ST_DAT: begin
                bus_cyc_o = dat_cyc_i;
                bus_we_o  = dat_we_i;
                bus_adr_o = dat_adr_i;
                bus_sel_o = dat_sel_i;
                bus_dat_o = dat_dat_i;
            end
            default: ;
        endcase
    end

    // Responses go only to the granted master; read data is a plain fanout
    always_comb begin
        ins_ack_o = gnt_ins & bus_ack_i;
        dat_ack_o = gnt_dat & bus_ack_i;
        ins_err_o = gnt_ins & tmo_hit;
        dat_err_o = gnt_dat & tmo_hit;
        ins_dat_o = bus_dat_i;
        dat_dat_o = bus_dat_i;
        grant_o   = state_q;
    end

    // Next-state: arbitrate from IDLE, release after every transaction
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ins_cyc_i && starved)
                    state_d = ST_INS;
                else if (dat_cyc_i)
                    state_d = ST_DAT;
                else if (ins_cyc_i)
                    state_d = ST_INS;
                else
                    state_d = ST_IDLE;
            end
            ST_INS, ST_DAT: begin
                // abort (cyc dropped), ack, or timeout all free the bus
                if (!gnt_cyc || ack_hit || tmo_hit)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Counter next values: timeout runs only while a grant persists,
    // starve counts refused instruction cycles and saturates
    always_comb begin
        tmo_d = '0;
        if (gnt_any && (state_d == state_q))
            tmo_d = tmo_q + 1'b1;

        starve_d = starve_q;
        if ((state_q == ST_IDLE) && (state_d == ST_INS))
            starve_d = '0;
        else if (!ins_cyc_i)
            starve_d = '0;
        else if ((state_q != ST_INS) && !starved)
            starve_d = starve_q + 1'b1;
    end

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
        end
    end

endmodule

// File: tb/tb_bexkat1_busarb.sv
// Bench for bexkat1_busarb: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_bexkat1_busarb;

    localparam int MAX_WAIT = 8;
    localparam int TIMEOUT  = 64;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ins_cyc_i, ins_we_i, dat_cyc_i, dat_we_i;
    logic [31:0] ins_adr_i, ins_dat_i, dat_adr_i, dat_dat_i;
    logic [3:0]  ins_sel_i, dat_sel_i;
    logic        ins_ack_o, ins_err_o, dat_ack_o, dat_err_o;
    logic [31:0] ins_dat_o, dat_dat_o;
    logic        bus_cyc_o, bus_we_o;
    logic [31:0] bus_adr_o, bus_dat_o, bus_dat_i;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [1:0]  grant_o;

    bexkat1_busarb #(.MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ins_cyc_i(ins_cyc_i), .ins_we_i(ins_we_i), .ins_adr_i(ins_adr_i),
        .ins_sel_i(ins_sel_i), .ins_dat_i(ins_dat_i),
        .ins_ack_o(ins_ack_o), .ins_err_o(ins_err_o), .ins_dat_o(ins_dat_o),
        .dat_cyc_i(dat_cyc_i), .dat_we_i(dat_we_i), .dat_adr_i(dat_adr_i),
        .dat_sel_i(dat_sel_i), .dat_dat_i(dat_dat_i),
        .dat_ack_o(dat_ack_o), .dat_err_o(dat_err_o), .dat_dat_o(dat_dat_o),
        .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
        .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
        .bus_ack_i(bus_ack_i), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level model: who owns the bus, how long the current
    // transaction has run, how many cycles the fetch side has been refused.
    int owner  = 0;   // 0 nobody, 1 fetch, 2 data
    int age    = 0;
    int waited = 0;
    // model responses of the last checked cycle, used by the stimulus
    bit r_iack, r_dack, r_ierr, r_derr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit owner_req();
        if (owner == 1) return ins_cyc_i;
        if (owner == 2) return dat_cyc_i;
        return 1'b0;
    endfunction

    // Compare all outputs against the model for this cycle, then advance it
    task automatic check_cycle();
        bit e_cyc, e_we, expired, done;
        logic [31:0] e_adr, e_wd;
        logic [3:0]  e_sel;
        int nxt;
        #1;
        e_cyc = owner_req();
        e_we = 0; e_adr = 0; e_wd = 0; e_sel = 0;
        if (owner == 1) begin e_we = ins_we_i; e_adr = ins_adr_i; e_wd = ins_dat_i; e_sel = ins_sel_i; end
        if (owner == 2) begin e_we = dat_we_i; e_adr = dat_adr_i; e_wd = dat_dat_i; e_sel = dat_sel_i; end
        if (owner == 0) e_cyc = 0;
        r_iack  = (owner == 1) && bus_ack_i;
        r_dack  = (owner == 2) && bus_ack_i;
        expired = (owner != 0) && e_cyc && !bus_ack_i && (age == TIMEOUT - 1);
        r_ierr  = (owner == 1) && expired;
        r_derr  = (owner == 2) && expired;

        chk("grant", grant_o, owner);
        chk("bus_cyc", bus_cyc_o, e_cyc);
        chk("bus_we", bus_we_o, e_we);
        chk("bus_adr", bus_adr_o, e_adr);
        chk("bus_sel", bus_sel_o, e_sel);
        chk("bus_dat", bus_dat_o, e_wd);
        chk("ins_ack", ins_ack_o, r_iack);
        chk("dat_ack", dat_ack_o, r_dack);
        chk("ins_err", ins_err_o, r_ierr);
        chk("dat_err", dat_err_o, r_derr);
        if (r_iack) chk("ins_rdata", ins_dat_o, bus_dat_i);
        if (r_dack) chk("dat_rdata", dat_dat_o, bus_dat_i);

        done = !e_cyc || bus_ack_i || expired;
        if (owner == 0) begin
            if (ins_cyc_i && waited >= MAX_WAIT) nxt = 1;
            else if (dat_cyc_i)                 nxt = 2;
            else if (ins_cyc_i)                 nxt = 1;
            else                                nxt = 0;
        end else begin
            nxt = done ? 0 : owner;
        end
        if ((owner == 0 && nxt == 1) || !ins_cyc_i) waited = 0;
        else if (owner != 1 && waited < MAX_WAIT)   waited++;
        age   = (nxt != 0 && nxt == owner) ? age + 1 : 0;
        owner = nxt;
    endtask

    // one directed cycle: drive at the falling edge, then check
    task automatic cyc(input bit ic, input bit dc, input bit ack);
        @(negedge clk_i);
        ins_cyc_i = ic;
        dat_cyc_i = dc;
        bus_ack_i = ack;
        check_cycle();
    endtask

    // random traffic state
    bit          i_req, d_req;
    int          first, cnt;
    bit          saw;
    int          ack_pct;

    initial begin
        rst_i = 1'b1;
        ins_cyc_i = 0; ins_we_i = 0; ins_adr_i = 0; ins_sel_i = 0; ins_dat_i = 0;
        dat_cyc_i = 0; dat_we_i = 0; dat_adr_i = 0; dat_sel_i = 0; dat_dat_i = 0;
        bus_dat_i = 0; bus_ack_i = 0;
        #2;
        // reset state
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_bus_cyc", bus_cyc_o, 1'b0);
        chk("rst_bus_adr", bus_adr_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // single data read, slave acks one cycle after seeing cyc
        dat_adr_i = 32'h0000_1000; dat_sel_i = 4'hF; dat_we_i = 0;
        bus_dat_i = 32'hDEAD_BEEF;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        chk("rd_bus_cyc_c1", bus_cyc_o, 1'b1);
        chk("rd_bus_adr_c1", bus_adr_o, 32'h0000_1000);
        cyc(0, 1, 1);
        chk("rd_dat_ack_c2", dat_ack_o, 1'b1);
        chk("rd_dat_data_c2", dat_dat_o, 32'hDEAD_BEEF);
        chk("rd_ins_ack_c2", ins_ack_o, 1'b0);
        cyc(0, 0, 0);
        chk("rd_bus_cyc_c3", bus_cyc_o, 1'b0);

        // simultaneous requests: data first, then fetch
        ins_adr_i = 32'h0000_2000; ins_sel_i = 4'hF;
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        chk("sim_dat_first", grant_o, 2'b10);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        chk("sim_ins_next", grant_o, 2'b01);
        chk("sim_ins_adr", bus_adr_o, 32'h0000_2000);
        cyc(0, 0, 0);

        // starvation: data hammers continuously with a zero-wait slave
        first = -1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            ins_cyc_i = (first < 0);
            dat_cyc_i = (first < 0);
            bus_ack_i = owner_req();
            check_cycle();
            if (grant_o == 2'b01 && first < 0) first = c;
        end
        chk("starve_ins_cycle", first, 9);
        // starve cleared on that grant, so data wins the next contest
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        chk("starve_cleared", grant_o, 2'b10);
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(0, 0, 0);

        // timeout: data granted, slave silent
        cyc(0, 1, 0);
        first = -1; saw = 0;
        for (int c = 0; c < 100 && first < 0; c++) begin
            cyc(0, 1, 0);
            if (dat_ack_o) saw = 1;
            if (dat_err_o) first = c;
        end
        chk("tmo_err_cycle", first, TIMEOUT - 1);
        chk("tmo_no_ack", saw, 1'b0);
        cyc(0, 0, 0);
        chk("tmo_idle_after", grant_o, 2'b00);
        chk("tmo_err_single", dat_err_o, 1'b0);

        // abort: fetch drops cyc while granted
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("abort_granted", grant_o, 2'b01);
        cyc(0, 0, 0);
        chk("abort_no_err", ins_err_o, 1'b0);
        cyc(0, 0, 0);
        chk("abort_idle", grant_o, 2'b00);

        // reset in the middle of a data grant
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        @(negedge clk_i);
        bus_ack_i = 1'b1;
        rst_i = 1'b1;
        #1;
        chk("rstmid_bus_cyc", bus_cyc_o, 1'b0);
        chk("rstmid_grant", grant_o, 2'b00);
        chk("rstmid_ack", dat_ack_o, 1'b0);
        chk("rstmid_err", dat_err_o, 1'b0);
        owner = 0; age = 0; waited = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        dat_cyc_i = 0; bus_ack_i = 0;
        check_cycle();

        // randomized traffic: busy slave first, then a mostly silent one
        i_req = 0; d_req = 0;
        for (int c = 0; c < 4000; c++) begin
            ack_pct = (c < 2500) ? 50 : 2;
            @(negedge clk_i);
            if (!i_req && $urandom_range(99) < 40) begin
                i_req = 1;
                ins_we_i = 0; ins_adr_i = $urandom; ins_sel_i = 4'hF; ins_dat_i = $urandom;
            end else if (i_req && $urandom_range(199) == 0) i_req = 0;
            if (!d_req && $urandom_range(99) < 40) begin
                d_req = 1;
                dat_we_i = $urandom; dat_adr_i = $urandom; dat_sel_i = $urandom; dat_dat_i = $urandom;
            end else if (d_req && $urandom_range(199) == 0) d_req = 0;
            ins_cyc_i = i_req;
            dat_cyc_i = d_req;
            bus_dat_i = $urandom;
            bus_ack_i = owner_req() && ($urandom_range(99) < ack_pct);
            check_cycle();
            if (r_iack || r_ierr) i_req = 0;
            if (r_dack || r_derr) d_req = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
